// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation encoding and
// the bit positions of the control vector carried into EX.
package rv32_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   localparam int CTRL_IS_LOAD   = 7;
   localparam int CTRL_IS_STORE  = 6;
   localparam int CTRL_IS_BRANCH = 5;
   localparam int CTRL_IS_JAL    = 4;
   localparam int CTRL_IS_JALR   = 3;
   localparam int CTRL_USE_PC_A  = 2;
   localparam int CTRL_USE_IMM_B = 1;
   localparam int CTRL_ILLEGAL   = 0;

   // funct7[5] only selects SUB on register-register ops and SRA on shifts.
   function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                          input logic       funct7b5,
                                          input logic       isRegReg);
      case (funct3)
         3'b000:  return (isRegReg && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational RV32I immediate extraction; the format is chosen from the
// opcode, and formats without an immediate yield zero.
module imm_gen
   import rv32_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [31:0] imm_o
);

   always_comb begin
      imm_o = '0;
      case (instr_i[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:
            imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         OPC_STORE:
            imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         OPC_BRANCH:
            imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm_o = {instr_i[31:12], 12'b0};
         OPC_JAL:
            imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
         default:
            imm_o = '0;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file addressing with writeback bypass,
// control decode, load-use stall and the ID/EX pipeline register.
module id_stage
   import rv32_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_if_valid,
   output logic            o_id_ready,
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   output logic [4:0]      o_rf_rs1,
   output logic [4:0]      o_rf_rs2,
   output logic            o_rf_re,
   input  logic [XLEN-1:0] i_rf_data1,
   input  logic [XLEN-1:0] i_rf_data2,
   input  logic            i_wb_wr,
   input  logic [4:0]      i_wb_rd,
   input  logic [XLEN-1:0] i_wb_data,
   input  logic            i_flush,
   input  logic            i_ex_ready,
   output logic            o_ex_valid,
   output logic [XLEN-1:0] o_ex_pc,
   output logic [XLEN-1:0] o_ex_rs1_data,
   output logic [XLEN-1:0] o_ex_rs2_data,
   output logic [XLEN-1:0] o_ex_imm,
   output logic [4:0]      o_ex_rd,
   output logic            o_ex_rd_wr,
   output logic [3:0]      o_ex_alu_op,
   output logic [7:0]      o_ex_ctrl,
   output logic [2:0]      o_ex_funct3
);

   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic [2:0]      funct3;
   alu_op_t         aluOp_d;
   logic [7:0]      ctrl_d;
   logic            rdWr_d, rs1Used, rs2Used, zeroRs1;
   logic [31:0]     imm_d;
   logic [XLEN-1:0] rs1Data_d, rs2Data_d;
   logic            loadUse, adv;

   logic            exValid_q, exRdWr_q;
   logic [XLEN-1:0] exPc_q, exRs1Data_q, exRs2Data_q, exImm_q;
   logic [4:0]      exRd_q;
   alu_op_t         exAluOp_q;
   logic [7:0]      exCtrl_q;
   logic [2:0]      exFunct3_q;

   assign opcode   = i_instr[6:0];
   assign rd       = i_instr[11:7];
   assign funct3   = i_instr[14:12];
   assign rs1      = i_instr[19:15];
   assign rs2      = i_instr[24:20];
   assign o_rf_rs1 = rs1;
   assign o_rf_rs2 = rs2;
   assign o_rf_re  = i_if_valid;

   imm_gen u_imm_gen (
      .instr_i (i_instr),
      .imm_o   (imm_d)
   );

   // Branches and JAL also form pc+imm so EX can reuse the adder for the target.
   always_comb begin
      aluOp_d = ALU_ADD;
      ctrl_d  = '0;
      rdWr_d  = 1'b0;
      rs1Used = 1'b1;
      rs2Used = 1'b0;
      zeroRs1 = 1'b0;
      case (opcode)
         OPC_OP: begin
            rdWr_d  = 1'b1;
            rs2Used = 1'b1;
            aluOp_d = alu_decode(funct3, i_instr[30], 1'b1);
         end
         OPC_OP_IMM: begin
            rdWr_d  = 1'b1;
            ctrl_d[CTRL_USE_IMM_B] = 1'b1;
            aluOp_d = alu_decode(funct3, i_instr[30], 1'b0);
         end
         OPC_LOAD: begin
            rdWr_d = 1'b1;
            ctrl_d[CTRL_IS_LOAD]   = 1'b1;
            ctrl_d[CTRL_USE_IMM_B] = 1'b1;
         end
         OPC_STORE: begin
            rs2Used = 1'b1;
            ctrl_d[CTRL_IS_STORE]  = 1'b1;
            ctrl_d[CTRL_USE_IMM_B] = 1'b1;
         end
         OPC_BRANCH: begin
            rs2Used = 1'b1;
            ctrl_d[CTRL_IS_BRANCH] = 1'b1;
            ctrl_d[CTRL_USE_PC_A]  = 1'b1;
            ctrl_d[CTRL_USE_IMM_B] = 1'b1;
         end
         OPC_JAL: begin
            rdWr_d  = 1'b1;
            rs1Used = 1'b0;
            ctrl_d[CTRL_IS_JAL]    = 1'b1;
            ctrl_d[CTRL_USE_PC_A]  = 1'b1;
            ctrl_d[CTRL_USE_IMM_B] = 1'b1;
         end
         OPC_JALR: begin
            rdWr_d = 1'b1;
            ctrl_d[CTRL_IS_JALR]   = 1'b1;
            ctrl_d[CTRL_USE_IMM_B] = 1'b1;
         end
         OPC_LUI: begin
            rdWr_d  = 1'b1;
            rs1Used = 1'b0;
            zeroRs1 = 1'b1;
            ctrl_d[CTRL_USE_IMM_B] = 1'b1;
         end
         OPC_AUIPC: begin
            rdWr_d  = 1'b1;
            rs1Used = 1'b0;
            ctrl_d[CTRL_USE_PC_A]  = 1'b1;
            ctrl_d[CTRL_USE_IMM_B] = 1'b1;
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
         end
         default: ctrl_d[CTRL_ILLEGAL] = 1'b1;
      endcase
      if (rd == 5'd0) rdWr_d = 1'b0;
   end

   // The register file is written at the same edge, so its read data is stale
   // for a register being written back this cycle.
   always_comb begin
      rs1Data_d = i_rf_data1;
      rs2Data_d = i_rf_data2;
      if (rs1 == 5'd0 || zeroRs1)         rs1Data_d = '0;
      else if (i_wb_wr && i_wb_rd == rs1) rs1Data_d = i_wb_data;
      if (rs2 == 5'd0)                    rs2Data_d = '0;
      else if (i_wb_wr && i_wb_rd == rs2) rs2Data_d = i_wb_data;
   end

   assign loadUse = exValid_q && exCtrl_q[CTRL_IS_LOAD] && (exRd_q != 5'd0) &&
                    ((rs1Used && rs1 == exRd_q) || (rs2Used && rs2 == exRd_q));
   assign adv        = !exValid_q || i_ex_ready;
   assign o_id_ready = rst_n && adv && !loadUse && !i_flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exValid_q   <= 1'b0;
         exPc_q      <= RESET_PC;
         exRs1Data_q <= '0;
         exRs2Data_q <= '0;
         exImm_q     <= '0;
         exRd_q      <= '0;
         exRdWr_q    <= 1'b0;
         exAluOp_q   <= ALU_ADD;
         exCtrl_q    <= '0;
         exFunct3_q  <= '0;
      end else if (i_flush) begin
         exValid_q <= 1'b0;
      end else if (adv && loadUse) begin
         exValid_q <= 1'b0;
      end else if (adv) begin
         exValid_q   <= i_if_valid;
         exPc_q      <= i_pc;
         exRs1Data_q <= rs1Data_d;
         exRs2Data_q <= rs2Data_d;
         exImm_q     <= imm_d;
         exRd_q      <= rd;
         exRdWr_q    <= rdWr_d;
         exAluOp_q   <= aluOp_d;
         exCtrl_q    <= ctrl_d;
         exFunct3_q  <= funct3;
      end
   end

   assign o_ex_valid    = exValid_q;
   assign o_ex_pc       = exPc_q;
   assign o_ex_rs1_data = exRs1Data_q;
   assign o_ex_rs2_data = exRs2Data_q;
   assign o_ex_imm      = exImm_q;
   assign o_ex_rd       = exRd_q;
   assign o_ex_rd_wr    = exRdWr_q;
   assign o_ex_alu_op   = exAluOp_q;
   assign o_ex_ctrl     = exCtrl_q;
   assign o_ex_funct3   = exFunct3_q;

endmodule
